// File: rtl/bram_responder_if.sv
// Request/response bundle between a RAM-access initiator and bram_responder.
// Latency: none (wires only). Backpressure: req_ready from responder, rsp_ready from initiator.
// Both channels use valid/ready and transfer on valid && ready at the rising clock edge.
interface bram_responder_if #(
    parameter int LANES = 4,
    parameter int DW    = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [LANES-1:0] req_write_enable;
    logic [31:0]      req_address;
    logic [DW-1:0]    req_data_in;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_data_out;
    logic             rsp_is_write;

    modport master (
        output req_valid, req_write_enable, req_address, req_data_in, rsp_ready,
        input  req_ready, rsp_valid, rsp_data_out, rsp_is_write
    );

    modport slave (
        input  req_valid, req_write_enable, req_address, req_data_in, rsp_ready,
        output req_ready, rsp_valid, rsp_data_out, rsp_is_write
    );
endinterface

// File: rtl/bram_responder.sv
// Single-port byte-lane-writable word RAM behind a valid/ready request/response port.
// Latency: read response valid one cycle after the RAM-read cycle (3-cycle read turnaround);
// writes take effect at accept. Backpressure: one request outstanding, req_ready only in IDLE.
// BRAM_RESPONDER_WRITE_ACK_EN: writes return an ack response (rsp_is_write=1) instead of none.
module bram_responder #(
    parameter int ADDRESS_BITWIDTH     = 16,
    parameter int DATA_BITWIDTH        = 32,
    parameter int DATA_COLUMN_BITWIDTH = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    bram_responder_if.slave       bus
);
    localparam int LANES = DATA_BITWIDTH / DATA_COLUMN_BITWIDTH;
    localparam int DEPTH = 2 ** ADDRESS_BITWIDTH;
    localparam int COL   = DATA_COLUMN_BITWIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [DATA_BITWIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [DATA_BITWIDTH-1:0]   ram_rd_q;
    logic [DATA_BITWIDTH-1:0]   mem [0:DEPTH-1];
    logic [ADDRESS_BITWIDTH-1:0] addr_idx;
    logic                       req_fire;
    logic                       is_write;
`ifdef BRAM_RESPONDER_WRITE_ACK_EN
    logic                       rsp_is_write_q, rsp_is_write_d;
`endif

    // Upper address bits alias onto the low ones; they are deliberately dropped.
    assign addr_idx = bus.req_address[ADDRESS_BITWIDTH-1:0];
    generate
        if (ADDRESS_BITWIDTH < 32) begin : g_addr_unused
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.req_address[31:ADDRESS_BITWIDTH];
        end
    endgenerate

    assign is_write      = |bus.req_write_enable;
    assign bus.req_ready = sys_rst_n && (state_q == IDLE);
    assign req_fire      = bus.req_valid && bus.req_ready;

    // RAM has no reset: contents survive reset so committed writes stay visible.
    always_ff @(posedge sys_clk) begin
        if (req_fire) begin
            if (is_write) begin
                for (int i = 0; i < LANES; i++) begin
                    if (bus.req_write_enable[i]) begin
                        mem[addr_idx][i*COL +: COL] <= bus.req_data_in[i*COL +: COL];
                    end
                end
            end else begin
                ram_rd_q <= mem[addr_idx];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= IDLE;
            rsp_data_q     <= '0;
`ifdef BRAM_RESPONDER_WRITE_ACK_EN
            rsp_is_write_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            rsp_data_q     <= rsp_data_d;
`ifdef BRAM_RESPONDER_WRITE_ACK_EN
            rsp_is_write_q <= rsp_is_write_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        rsp_data_d     = rsp_data_q;
`ifdef BRAM_RESPONDER_WRITE_ACK_EN
        rsp_is_write_d = rsp_is_write_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    if (is_write) begin
`ifdef BRAM_RESPONDER_WRITE_ACK_EN
                        state_d        = RESP;
                        rsp_data_d     = '0;
                        rsp_is_write_d = 1'b1;
`endif
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                state_d    = RESP;
                rsp_data_d = ram_rd_q;
`ifdef BRAM_RESPONDER_WRITE_ACK_EN
                rsp_is_write_d = 1'b0;
`endif
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d    = IDLE;
                    rsp_data_d = '0;
`ifdef BRAM_RESPONDER_WRITE_ACK_EN
                    rsp_is_write_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rsp_valid    = (state_q == RESP);
    assign bus.rsp_data_out = rsp_data_q;
`ifdef BRAM_RESPONDER_WRITE_ACK_EN
    assign bus.rsp_is_write = rsp_is_write_q;
`else
    assign bus.rsp_is_write = 1'b0;
`endif
endmodule
